// File: rtl/derivative_filter.sv
// ---------------------------------------------------------------------------
// derivative_filter
//
// Lagged-difference derivative stage for the PID datapath. It sits between
// the error subtractor and the Kd gain multiplier.
//
// Signed error samples are accepted on err_valid and kept in a DEPTH-entry
// history. Once the history is full ("primed"), each accepted sample produces
// the result err[n] - err[n-DEPTH], saturated to OUT_WIDTH bits and presented
// two cycles after the sample was accepted.
//
// Optional feature (compile-time macro DERIV_LPF_EN):
//   When this macro is defined, a first-order low-pass filter with
//   coefficient 2^-LPF_SHIFT is applied to the difference before saturation.
//   When it is undefined, no filter state exists and LPF_SHIFT has no effect
//   on the result.
//
// Handshake: deriv_valid is a one-cycle strobe with no ready signal. The
// consumer must take every strobe. deriv_out and deriv_sat change only
// together with a strobe, or when they are zeroed by clear or reset.
//
// Parameters:
//   ADC_WIDTH  error sample width, two's complement
//   OUT_WIDTH  derivative output width, 2..ADC_WIDTH+4
//   DEPTH      lag in samples, 1..16
//   LPF_SHIFT  filter coefficient exponent, 1..6 (filter build only)
//
// Ports:
//   clk          system clock
//   n_rst        asynchronous active-low reset; all state and outputs go to 0
//   clear        synchronous flush; takes priority over err_valid
//   err_valid    err_in carries a new sample this cycle
//   err_in       signed error sample
//   primed       history holds DEPTH samples
//   deriv_valid  one-cycle strobe; deriv_out/deriv_sat are new
//   deriv_out    signed derivative, held between strobes
//   deriv_sat    deriv_out was clamped; held with deriv_out
// ---------------------------------------------------------------------------
module derivative_filter #(
    parameter int ADC_WIDTH = 8,
    parameter int OUT_WIDTH = 10,
    parameter int DEPTH     = 4,
    parameter int LPF_SHIFT = 2
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        clear,
    input  logic                        err_valid,
    input  logic signed [ADC_WIDTH-1:0] err_in,
    output logic                        primed,
    output logic                        deriv_valid,
    output logic signed [OUT_WIDTH-1:0] deriv_out,
    output logic                        deriv_sat
);

    // Exact difference of two ADC_WIDTH samples needs one extra bit.
    localparam int DIFF_W = ADC_WIDTH + 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    // The saturation compare is done in a width wide enough for both the
    // raw difference and the filter accumulator, and for any legal OUT_WIDTH.
    localparam int SAT_W  = ADC_WIDTH + LPF_SHIFT + 6;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic signed [SAT_W-1:0] SAT_MAX =
        {{(SAT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SAT_W-1:0] SAT_MIN =
        {{(SAT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // -----------------------------------------------------------------------
    // Sample history and fill counter
    // -----------------------------------------------------------------------
    logic signed [ADC_WIDTH-1:0] hist_q [DEPTH];
    logic [CNT_W-1:0]            count_q;
    logic [CNT_W-1:0]            count_d;
    logic                        accept;

    // clear drops a coincident sample.
    assign accept = err_valid && !clear;
    assign primed = (count_q == CNT_FULL);

    // hist_q[0] holds the newest sample and hist_q[DEPTH-1] the oldest.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else if (err_valid) begin
            hist_q[0] <= err_in;
            for (int i = 1; i < DEPTH; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end

    // The counter saturates at DEPTH; primed stays high until clear or reset.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (err_valid && !primed) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: exact lagged difference
    // -----------------------------------------------------------------------
    logic signed [DIFF_W-1:0] diff_d;
    logic signed [DIFF_W-1:0] diff_q;
    logic                     s1_valid_q;

    // Both operands are sign-extended first, so the difference cannot wrap.
    assign diff_d = DIFF_W'(err_in) - DIFF_W'(hist_q[DEPTH-1]);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid_q <= 1'b0;
            diff_q     <= '0;
        end else if (clear) begin
            s1_valid_q <= 1'b0;
            diff_q     <= '0;
        end else begin
            // Samples that arrive before the history is full are stored
            // but produce no result.
            s1_valid_q <= accept && primed;
            if (accept && primed) begin
                diff_q <= diff_d;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: optional low-pass filter, then saturation
    // -----------------------------------------------------------------------
    logic signed [SAT_W-1:0] stage_val;

`ifdef DERIV_LPF_EN
    localparam int ACC_W = DIFF_W + LPF_SHIFT;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_ext;
    logic signed [ACC_W-1:0] filt;
    logic                    lpf_init_q;

    assign acc_ext = ACC_W'(diff_q);

    // The first difference after priming, clear or reset preloads the
    // accumulator. That makes the first filtered output equal to the
    // difference itself instead of ramping up from zero. Later differences
    // use a leaky integrator: acc += diff - acc/2^LPF_SHIFT. With a bounded
    // input, this keeps |acc| within ACC_W bits.
    always_comb begin
        acc_d = acc_q;
        if (!lpf_init_q) begin
            acc_d = acc_ext <<< LPF_SHIFT;
        end else begin
            acc_d = acc_q + acc_ext - (acc_q >>> LPF_SHIFT);
        end
    end

    assign filt      = acc_d >>> LPF_SHIFT;
    assign stage_val = SAT_W'(filt);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q      <= '0;
            lpf_init_q <= 1'b0;
        end else if (clear) begin
            acc_q      <= '0;
            lpf_init_q <= 1'b0;
        end else if (s1_valid_q) begin
            acc_q      <= acc_d;
            lpf_init_q <= 1'b1;
        end
    end
`else
    assign stage_val = SAT_W'(diff_q);
`endif

    logic signed [OUT_WIDTH-1:0] out_d;
    logic                        sat_d;

    always_comb begin
        out_d = stage_val[OUT_WIDTH-1:0];
        sat_d = 1'b0;
        if (stage_val > SAT_MAX) begin
            out_d = OUT_MAX;
            sat_d = 1'b1;
        end else if (stage_val < SAT_MIN) begin
            out_d = OUT_MIN;
            sat_d = 1'b1;
        end
    end

    logic                        deriv_valid_q;
    logic signed [OUT_WIDTH-1:0] deriv_out_q;
    logic                        deriv_sat_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            deriv_valid_q <= 1'b0;
            deriv_out_q   <= '0;
            deriv_sat_q   <= 1'b0;
        end else if (clear) begin
            deriv_valid_q <= 1'b0;
            deriv_out_q   <= '0;
            deriv_sat_q   <= 1'b0;
        end else begin
            deriv_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                deriv_out_q <= out_d;
                deriv_sat_q <= sat_d;
            end
        end
    end

    assign deriv_valid = deriv_valid_q;
    assign deriv_out   = deriv_out_q;
    assign deriv_sat   = deriv_sat_q;

endmodule

// File: tb/tb_derivative_filter.sv
// ---------------------------------------------------------------------------
// tb_derivative_filter
//
// Drives two instances of derivative_filter from the same stimulus:
//   dut_a  OUT_WIDTH=10 (default)
//   dut_b  OUT_WIDTH=8
//
// A behavioural model keeps the sample history as a queue and expected
// strobes in exp_q, each tagged with the cycle it must appear in. Every
// cycle, primed, deriv_valid, deriv_out and deriv_sat of both instances are
// compared with the model. Directed tests also check literal results.
// Filter behaviour follows DERIV_LPF_EN.
// ---------------------------------------------------------------------------
module tb_derivative_filter;

    localparam int ADC_WIDTH = 8;
    localparam int DEPTH     = 4;
    localparam int LPF_SHIFT = 2;

    // -------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------
    logic clk = 1'b0;
    logic n_rst;
    logic clear;
    logic err_valid;
    logic signed [ADC_WIDTH-1:0] err_in;

    logic                primed_a, valid_a, sat_a;
    logic signed [9:0]   out_a;
    logic                primed_b, valid_b, sat_b;
    logic signed [7:0]   out_b;

    always #5 clk = ~clk;

    derivative_filter #(
        .ADC_WIDTH(ADC_WIDTH), .OUT_WIDTH(10), .DEPTH(DEPTH), .LPF_SHIFT(LPF_SHIFT)
    ) dut_a (
        .clk(clk), .n_rst(n_rst), .clear(clear), .err_valid(err_valid), .err_in(err_in),
        .primed(primed_a), .deriv_valid(valid_a), .deriv_out(out_a), .deriv_sat(sat_a)
    );

    derivative_filter #(
        .ADC_WIDTH(ADC_WIDTH), .OUT_WIDTH(8), .DEPTH(DEPTH), .LPF_SHIFT(LPF_SHIFT)
    ) dut_b (
        .clk(clk), .n_rst(n_rst), .clear(clear), .err_valid(err_valid), .err_in(err_in),
        .primed(primed_b), .deriv_valid(valid_b), .deriv_out(out_b), .deriv_sat(sat_b)
    );

    // -------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------
    typedef struct {
        int due;
        int v_a;
        int s_a;
        int v_b;
        int s_b;
    } exp_t;

    exp_t exp_q[$];
    int   hist_m[$];     // newest sample at index 0
    int   cyc;
    int   acc_m;
    bit   lpf_init_m;
    int   exp_valid;
    int   hv_a, hs_a, hv_b, hs_b;

    int   log_a[$];      // values seen on dut_a strobes
    int   n_tests;
    int   n_fail;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic void saturate(input int v, input int w, output int o, output int s);
        int hi;
        int lo;
        hi = (1 <<< (w - 1)) - 1;
        lo = -(1 <<< (w - 1));
        if (v > hi) begin
            o = hi; s = 1;
        end else if (v < lo) begin
            o = lo; s = 1;
        end else begin
            o = v;  s = 0;
        end
    endfunction

    function automatic int filter_m(input int diff);
`ifdef DERIV_LPF_EN
        if (!lpf_init_m) begin
            acc_m      = diff * (1 << LPF_SHIFT);
            lpf_init_m = 1'b1;
        end else begin
            acc_m = acc_m + diff - (acc_m >>> LPF_SHIFT);
        end
        return acc_m >>> LPF_SHIFT;
`else
        return diff;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        hist_m.delete();
        acc_m      = 0;
        lpf_init_m = 1'b0;
        exp_valid  = 0;
        hv_a = 0; hs_a = 0; hv_b = 0; hs_b = 0;
    endtask

    // One rising edge with the given inputs applied.
    task automatic model_edge(input bit v, input int d, input bit c);
        exp_t e;
        int   f;
        cyc++;
        if (c) begin
            model_reset();
            return;
        end
        exp_valid = 0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            exp_valid = 1;
            hv_a = e.v_a; hs_a = e.s_a; hv_b = e.v_b; hs_b = e.s_b;
        end
        if (v) begin
            if (hist_m.size() == DEPTH) begin
                f = filter_m(d - hist_m[DEPTH-1]);
                e.due = cyc + 1;
                saturate(f, 10, e.v_a, e.s_a);
                saturate(f, 8,  e.v_b, e.s_b);
                exp_q.push_back(e);
            end
            hist_m.push_front(d);
            if (hist_m.size() > DEPTH) void'(hist_m.pop_back());
        end
    endtask

    task automatic check_outputs();
        int pr;
        pr = (hist_m.size() == DEPTH) ? 1 : 0;
        check("primed_a", int'(primed_a), pr);
        check("primed_b", int'(primed_b), pr);
        check("valid_a",  int'(valid_a),  exp_valid);
        check("valid_b",  int'(valid_b),  exp_valid);
        check("out_a",    int'(out_a),    hv_a);
        check("sat_a",    int'(sat_a),    hs_a);
        check("out_b",    int'(out_b),    hv_b);
        check("sat_b",    int'(sat_b),    hs_b);
        if (valid_a) log_a.push_back(int'(out_a));
    endtask

    // -------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------
    task automatic step(input bit v, input int d, input bit c);
        @(negedge clk);
        err_valid = v;
        err_in    = ADC_WIDTH'(d);
        clear     = c;
        @(posedge clk);
        model_edge(v, d, c);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    // Asserts reset right now. The outputs must be zero immediately.
    task automatic reset_now();
        n_rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        err_valid = 1'b0;
        clear     = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 0, 1'b0);
        #1;
        check_outputs();
    endtask

    // -------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------
    initial begin
        int exp_l0, exp_l1, exp_l2;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        n_rst     = 1'b1;
        clear     = 1'b0;
        err_valid = 1'b0;
        err_in    = '0;
        model_reset();
        #2;
        reset_now();

        // Prime / lag: 10..50 back to back.
        log_a.delete();
        step(1, 10, 0); step(1, 20, 0); step(1, 30, 0);
        check("lag_unprimed", int'(primed_a), 0);
        step(1, 40, 0);
        check("lag_primed", int'(primed_a), 1);
        step(1, 50, 0);
        check("lag_no_early_strobe", log_a.size(), 0);
        idle(1);
        check("lag_strobe_count", log_a.size(), 1);
        check("lag_value", int'(out_a), 40);
        idle(1);

        // Saturation, upper side.
        step(0, 0, 1);
        step(1, -128, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        step(1, 127, 0);
        idle(2);
        check("sat_hi_a_out", int'(out_a), 255);
        check("sat_hi_a_sat", int'(sat_a), 0);
        check("sat_hi_b_out", int'(out_b), 127);
        check("sat_hi_b_sat", int'(sat_b), 1);

        // Saturation, lower side.
        step(0, 0, 1);
        step(1, 127, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        step(1, -128, 0);
        idle(2);
        check("sat_lo_a_out", int'(out_a), -255);
        check("sat_lo_a_sat", int'(sat_a), 0);
        check("sat_lo_b_out", int'(out_b), -128);
        check("sat_lo_b_sat", int'(sat_b), 1);

        // Clear has priority over a coincident sample.
        for (int i = 0; i < 6; i++) step(1, i * 7, 0);
        step(1, 99, 1);
        check("clr_primed_drop", int'(primed_a), 0);
        log_a.delete();
        for (int i = 0; i < 4; i++) step(1, i, 0);
        idle(2);
        check("clr_no_strobe", log_a.size(), 0);
        step(1, 60, 0);
        idle(1);
        check("clr_fifth_strobe", log_a.size(), 1);
        check("clr_fifth_value", int'(out_a), 60);

        // Reset one cycle after an accepted primed sample.
        for (int i = 0; i < 5; i++) step(1, 11 * i, 0);
        reset_now();
        log_a.delete();
        for (int i = 0; i < 4; i++) step(1, -3 * i, 0);
        idle(2);
        check("rst_no_strobe", log_a.size(), 0);
        step(1, 5, 0);
        idle(1);
        check("rst_reprime_strobe", log_a.size(), 1);

        // Differences 40, 0, 0.
        step(0, 0, 1);
        log_a.delete();
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        step(1, 40, 0); step(1, 0, 0); step(1, 0, 0);
        idle(2);
`ifdef DERIV_LPF_EN
        exp_l0 = 40; exp_l1 = 30; exp_l2 = 22;
`else
        exp_l0 = 40; exp_l1 = 0;  exp_l2 = 0;
`endif
        check("lpf_count", log_a.size(), 3);
        check("lpf_out0", (log_a.size() > 0) ? log_a[0] : -9999, exp_l0);
        check("lpf_out1", (log_a.size() > 1) ? log_a[1] : -9999, exp_l1);
        check("lpf_out2", (log_a.size() > 2) ? log_a[2] : -9999, exp_l2);

        // Gapped input: one sample every third cycle.
        step(0, 0, 1);
        log_a.delete();
        for (int i = 0; i < 6; i++) begin
            step(1, (i == 5) ? 70 : 10 * (i + 1), 0);
            idle(2);
        end
`ifdef DERIV_LPF_EN
        exp_l1 = 42;
`else
        exp_l1 = 50;
`endif
        check("gap_count", log_a.size(), 2);
        check("gap_out0", (log_a.size() > 0) ? log_a[0] : -9999, 40);
        check("gap_out1", (log_a.size() > 1) ? log_a[1] : -9999, exp_l1);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 255)) - 128,
                 ($urandom_range(0, 40) == 0));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
